// File: rtl/mem_initiator.sv
// Load/store bus initiator for a word-addressed memory: sub-word loads with extension, sub-word stores by read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word requests complete with an error and no memory access.
module mem_initiator #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // Request context; only meaningful once a request is accepted, so no reset.
  logic [31:0]       addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic [31:0]       data_q;

  logic              misalign;
  logic              timeout_hit;
  logic              accept;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] a,
                                              input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] a, input logic [1:0] size);
    store_merge = word;
    case (size)
      2'b00: begin
        case (a)
          2'd0:    store_merge[7:0]   = wdata[7:0];
          2'd1:    store_merge[15:8]  = wdata[7:0];
          2'd2:    store_merge[23:16] = wdata[7:0];
          default: store_merge[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) store_merge[31:16] = wdata[15:0];
        else      store_merge[15:0]  = wdata[15:0];
      end
      default: store_merge = wdata;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                    (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign accept      = (state_q == IDLE) && req_valid_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_rd_en_o  = 1'b0;
    mem_wr_en_o  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        cnt_d       = '0;
        err_d       = 1'b0;
        if (req_valid_i) begin
          if (misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (req_we_i && req_size_i[1]) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_rd_en_o = 1'b1;
        if (mem_ack_i) begin
          state_d = RD_DATA;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_DATA: begin
        cnt_d   = '0;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        mem_wr_en_o = 1'b1;
        if (mem_ack_i) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        cnt_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Store data doubles as the merged write word and, for loads, the extended result.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr_i;
      size_q <= req_size_i;
      uns_q  <= req_unsigned_i;
      we_q   <= req_we_i;
      data_q <= req_wdata_i;
    end else if (state_q == RD_DATA) begin
      data_q <= we_q ? store_merge(mem_data_i, data_q, addr_q[1:0], size_q)
                     : load_extend(mem_data_i, addr_q[1:0], size_q, uns_q);
    end
  end

  assign resp_rdata_o = ((state_q == RESP) && !we_q && !err_q) ? data_q : 32'h0;
  assign resp_err_o   = (state_q == RESP) && err_q;
  assign mem_addr_o   = (mem_rd_en_o || mem_wr_en_o) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_data_o   = mem_wr_en_o ? data_q : 32'h0;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: memory model with programmable ack delay, response scoreboard, bus monitor.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  mem_initiator #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_delay enable cycles, read data one cycle after the acked edge.
  logic [31:0] mem [0:255];
  int          hold = 0;
  int          ack_delay = 0;
  bit          ack_never = 1'b0;
  bit          force_ack = 1'b0;
  bit          pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_val = 32'h0;
  logic        model_ack;

  assign model_ack = (mem_rd_en || mem_wr_en) && !ack_never && (hold >= ack_delay);
  assign mem_ack   = model_ack || force_ack;

  always @(posedge clk) begin
    if ((mem_rd_en || mem_wr_en) && !model_ack) hold <= hold + 1;
    else hold <= 0;
    if (mem_rd_en && mem_ack) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_wr_en && mem_ack) mem[mem_addr[9:2]] <= mem_wdata;
    if (pl_en) mem[pl_idx] <= pl_val;
  end

  // Bus monitor
  int          rd_cycles = 0, wr_cycles = 0, overlap = 0, unstable = 0;
  logic        prev_en = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;

  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) rd_cycles <= rd_cycles + 1;
    if (mem_wr_en === 1'b1) wr_cycles <= wr_cycles + 1;
    if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) overlap <= overlap + 1;
    if ((mem_rd_en || mem_wr_en) && prev_en && (mem_addr !== prev_addr || mem_wdata !== prev_data))
      unstable <= unstable + 1;
    prev_en   <= mem_rd_en || mem_wr_en;
    prev_addr <= mem_addr;
    prev_data <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    bit   got;
    int   lat;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    @(negedge clk);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    exp_q.push_back(e);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s_noresp observed=none expected=resp_valid", tag);
    end
    if (got) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
      chk({tag, "_lat"}, lat, e.lat);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  int rd0, wr0;

  initial begin
    #400000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    preload(8'h10, 32'h8899AABB);
    do_req("ldb_s41", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
    do_req("ldh_u42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'h00008899, 1'b0, 3);
    do_req("ldh_s42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 3);
    do_req("ldb_u40", 1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 32'h000000BB, 1'b0, 3);
    do_req("ldb_s43", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'hFFFFFF88, 1'b0, 3);
    do_req("ldw_40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 3);
    do_req("ldw3_40", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 3);

    preload(8'h10, 32'h11223344);
    rd0 = rd_cycles; wr0 = wr_cycles;
    do_req("stb_43", 1'b1, 2'b00, 1'b0, 32'h43, 32'h5A, 32'h0, 1'b0, 4);
    chk("stb_mem", mem[8'h10], 32'h5A223344);
    chk("stb_rd_cyc", rd_cycles - rd0, 1);
    chk("stb_wr_cyc", wr_cycles - wr0, 1);
    do_req("sth_40", 1'b1, 2'b01, 1'b0, 32'h40, 32'h1234BEEF, 32'h0, 1'b0, 4);
    chk("sth_mem", mem[8'h10], 32'h5A22BEEF);
    do_req("ldw_after", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h5A22BEEF, 1'b0, 3);

    ack_delay = 3;
    rd0 = rd_cycles; wr0 = wr_cycles;
    do_req("stw_80", 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0, 1'b0, 5);
    chk("stw_mem", mem[8'h20], 32'hDEADBEEF);
    chk("stw_wr_cyc", wr_cycles - wr0, 4);
    chk("stw_rd_cyc", rd_cycles - rd0, 0);

    ack_delay = 15;
    rd0 = rd_cycles;
    do_req("ack_at_limit", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0, 18);
    chk("ack_at_limit_rd_cyc", rd_cycles - rd0, 16);

    ack_delay = 0;
    ack_never = 1'b1;
    rd0 = rd_cycles;
    do_req("tmo_ld", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 17);
    chk("tmo_ld_rd_cyc", rd_cycles - rd0, 16);
    chk("tmo_ready", {31'h0, req_ready}, 32'h1);
    rd0 = rd_cycles; wr0 = wr_cycles;
    do_req("tmo_stb", 1'b1, 2'b00, 1'b0, 32'h82, 32'h77, 32'h0, 1'b1, 17);
    chk("tmo_stb_wr_cyc", wr_cycles - wr0, 0);
    chk("tmo_stb_mem", mem[8'h20], 32'hDEADBEEF);
    ack_never = 1'b0;

    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_valid", {31'h0, resp_valid}, 32'h0);
    chk("idle_ack_ready", {31'h0, req_ready}, 32'h1);
    force_ack = 1'b0;
    do_req("post_idle_ack", 1'b0, 2'b00, 1'b1, 32'h81, 32'h0, 32'h000000BE, 1'b0, 3);

    preload(8'h18, 32'hCAFEF00D);
    ack_delay = 2;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0; req_addr = 32'h61; req_wdata = 32'h11;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) break;
    end
    chk("rst_wr_seen", {31'h0, mem_wr_en}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_wr_en", {31'h0, mem_wr_en}, 32'h0);
    chk("rst_mid_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_mem", mem[8'h18], 32'hCAFEF00D);
    ack_delay = 0;

    rd0 = rd_cycles;
`ifdef MISALIGN_TRAP_EN
    do_req("mis_ldw42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1);
    chk("mis_rd_cyc", rd_cycles - rd0, 0);
    do_req("mis_ldh43", 1'b0, 2'b01, 1'b1, 32'h43, 32'h0, 32'h0, 1'b1, 1);
`else
    do_req("mis_ldw42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h5A22BEEF, 1'b0, 3);
    chk("mis_rd_cyc", rd_cycles - rd0, 1);
    do_req("mis_ldh43", 1'b0, 2'b01, 1'b1, 32'h43, 32'h0, 32'h00005A22, 1'b0, 3);
`endif

    chk("bus_overlap", overlap, 0);
    chk("bus_unstable", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
